dot_product_sorter: RTL and testbench

- Downstream stage of the dot-product unit.
- Collects a frame of complex dot-product results and computes the squared magnitude of each.
- Keeps the results in a descending-order insertion-sort register array, then streams the sorted list out with each result's arrival index.
- Feeds the V2V candidate-selection logic.

---
 rtl/dot_product_sorter.sv | 166 ++++++++++++++++
 tb/tb_dot_product_sorter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dot_product_sorter.sv
// dot_product_sorter: collects a frame of complex dot-product results, forms
// re^2+im^2 for each, keeps them in a descending insertion-sort register array
// and streams the sorted list out with each result's arrival index.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             input handshake
//   in_real, in_imag              signed result components (WIDTH bits)
//   in_last                       final result of the frame
//   out_valid/out_ready           output handshake
//   out_mag                       unsigned squared magnitude (2*WIDTH bits)
//   out_idx                       arrival index within the frame
//   out_last                      final sorted entry of the frame
//   busy                          low only when idle in FILL with nothing held
module dot_product_sorter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out_mag,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned MAG_W = 2 * WIDTH;
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             vld;
    logic [MAG_W-1:0] mag;
    logic [IDX_W-1:0] idx;
  } entry_t;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    LASTINS = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  entry_t           slot     [DEPTH];
  entry_t           slot_nxt [DEPTH];
  entry_t           stage;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] arr_cnt;
  logic [DEPTH-1:0] gt;

  logic             in_xfer;
  logic             out_xfer;
  logic             frame_end;
  logic             drain_done;

  logic signed [MAG_W-1:0] re_ext;
  logic signed [MAG_W-1:0] im_ext;
  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;
  logic [MAG_W-1:0]        mag_c;

  // Squared magnitude; both squares are non-negative so the sum fits unsigned.
  assign re_ext = MAG_W'(in_real);
  assign im_ext = MAG_W'(in_imag);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign mag_c  = $unsigned(re_sq) + $unsigned(im_sq);

  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  // Frame closes on in_last or on the transfer that fills the last slot.
  assign frame_end  = in_xfer & (in_last | (arr_cnt == CNT_W'(DEPTH - 1)));
  assign drain_done = out_xfer & (count == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (frame_end) state_nxt = LASTINS;
      LASTINS: state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_mag   = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      busy = !((state == FILL) && (count == '0) && !stage.vld);
      case (state)
        FILL: in_ready = 1'b1;
        DRAIN: begin
          out_valid = 1'b1;
          out_mag   = slot[0].mag;
          out_idx   = slot[0].idx;
          out_last  = (count == CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

  // Array update: shift up on drain, or insert the staged entry.
  // gt[] is monotonic (array descending, empties at the bottom), so slot i
  // shifts down exactly when the insertion point lies above it. Ties do not
  // set gt, keeping earlier arrivals ahead.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      gt[i]       = !slot[i].vld || (stage.mag > slot[i].mag);
      slot_nxt[i] = slot[i];
    end
    if (state == DRAIN) begin
      if (out_xfer) begin
        for (int i = 0; i < DEPTH - 1; i++) slot_nxt[i] = slot[i+1];
        slot_nxt[DEPTH-1] = '0;
      end
    end else if (stage.vld) begin
      for (int i = 0; i < DEPTH; i++)
        if (gt[i]) slot_nxt[i] = '{vld: 1'b1, mag: stage.mag, idx: stage.idx};
      for (int i = 1; i < DEPTH; i++)
        if (gt[i-1]) slot_nxt[i] = slot[i-1];
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
      stage   <= '0;
      count   <= '0;
      arr_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot[i] <= slot_nxt[i];
      stage.vld <= in_xfer;
      if (in_xfer) begin
        stage.mag <= mag_c;
        stage.idx <= arr_cnt[IDX_W-1:0];
      end
      if (drain_done)   arr_cnt <= '0;
      else if (in_xfer) arr_cnt <= arr_cnt + CNT_W'(1);
      if (stage.vld)     count <= count + CNT_W'(1);
      else if (out_xfer) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dot_product_sorter.sv
// Directed self-checking bench for dot_product_sorter (WIDTH=8, DEPTH=4).
module tb_dot_product_sorter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 2;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_real;
  logic signed [WIDTH-1:0] in_imag;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*WIDTH-1:0]      out_mag;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;
  logic                    busy;

  int n_cmp = 0;
  int n_err = 0;

  dot_product_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mag  (out_mag),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One input transfer; returns #1 after the accepting edge.
  task automatic send(input logic signed [WIDTH-1:0] re, input logic signed [WIDTH-1:0] im,
                      input logic last);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for an entry, check it, then accept it.
  task automatic expect_out(input string tag, input int mag, input int idx, input logic last);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_mag"}, 32'(out_mag), 32'(mag));
    check({tag, "_idx"}, 32'(out_idx), 32'(idx));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    check({tag, "_inrdy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic send_frame4();
    send(8'sd3, 8'sd4, 1'b0);
    send(8'sd1, 8'sd1, 1'b0);
    send(-8'sd6, 8'sd0, 1'b0);
    send(8'sd0, 8'sd5, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset behaviour
    tick(); tick();
    check("rst_inrdy", 32'(in_ready), 32'd0);
    check("rst_outvld", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_inrdy", 32'(in_ready), 32'd1);
    tick(); tick(); tick();
    check("idle_inrdy", 32'(in_ready), 32'd1);
    check("idle_outvld", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_mag", 32'(out_mag), 32'd0);

    // 4-entry frame with implicit end; mags 25,2,36,25
    send_frame4();
    check("f1_lat_vld", 32'(out_valid), 32'd0);
    check("f1_lat_inrdy", 32'(in_ready), 32'd0);
    tick();
    check("f1_lat_vld2", 32'(out_valid), 32'd1);
    expect_out("f1_e0", 36, 2, 1'b0);
    expect_out("f1_e1", 25, 0, 1'b0);
    expect_out("f1_e2", 25, 3, 1'b0);
    expect_out("f1_e3", 2, 1, 1'b1);
    check("f1_done_inrdy", 32'(in_ready), 32'd1);
    check("f1_done_vld", 32'(out_valid), 32'd0);
    check("f1_done_busy", 32'(busy), 32'd0);

    // 2-entry frame with in_last; in_valid held during drain must be ignored
    send(8'sd2, 8'sd0, 1'b0);
    send(8'sd0, -8'sd3, 1'b1);
    in_valid = 1'b1; in_real = 8'sd7; in_imag = 8'sd7;
    expect_out("f2_e0", 9, 1, 1'b0);
    in_valid = 1'b0;
    expect_out("f2_e1", 4, 0, 1'b1);
    check("f2_done_inrdy", 32'(in_ready), 32'd1);

    // 4-entry frame with a 3-cycle stall mid-drain
    send_frame4();
    expect_out("f3_e0", 36, 2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("f3_hold_vld", 32'(out_valid), 32'd1);
      check("f3_hold_mag", 32'(out_mag), 32'd25);
      check("f3_hold_idx", 32'(out_idx), 32'd0);
      check("f3_hold_inrdy", 32'(in_ready), 32'd0);
    end
    expect_out("f3_e1", 25, 0, 1'b0);
    expect_out("f3_e2", 25, 3, 1'b0);
    expect_out("f3_e3", 2, 1, 1'b1);

    // Extreme magnitude
    send(-8'sd128, -8'sd128, 1'b1);
    expect_out("ext", 32768, 0, 1'b1);

    // Reset mid-drain
    send_frame4();
    expect_out("f5_e0", 36, 2, 1'b0);
    expect_out("f5_e1", 25, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("f5_rst_vld", 32'(out_valid), 32'd0);
    check("f5_rst_inrdy", 32'(in_ready), 32'd1);
    send(8'sd1, 8'sd0, 1'b1);
    expect_out("f6_e0", 1, 0, 1'b1);
    check("f6_done_vld", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
